crc_tx_arbiter: RTL

- Schedules packet transmission into the CRC encoder, which writes packet bytes into the TX packet buffer.
- Shares the encoder between two packet sources:
  - requester 0: voice, high priority
  - requester 1: data/control
- Waits for the encoder to be idle (sts low), then streams exactly PKT_LEN contiguous bytes with D_TX_ready held high, tags each packet with a packet number, and waits for the encoder to finish before the next grant.

---
 rtl/crc_tx_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/crc_tx_arbiter.sv
// crc_tx_arbiter
//   Shares the CRC encoder between a high-priority voice source (req0) and a
//   data/control source (req1). Waits for the encoder to go idle, grants one
//   source, streams exactly PKT_LEN contiguous bytes into the encoder, tags the
//   packet with a 6-bit sequence number and waits for the encoder to finish
//   before the next grant.
//
//   Optional build macro: CRC_ARB_WDOG_EN -- adds a watchdog on the encoder
//   busy flag after each packet (limit WDOG_CYCLES); without it wdog_err is 0.
//
// Ports
//   clk_40mhz       in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   req0_avail      in   voice FIFO holds a complete packet
//   req0_byte  [7:0] in  voice FIFO head byte (first-word fall-through)
//   req0_pop        out  consume voice head byte
//   req1_avail      in   data FIFO holds a complete packet
//   req1_byte  [7:0] in  data FIFO head byte
//   req1_pop        out  consume data head byte
//   grant      [1:0] out one-hot owner of the current packet, 00 when none
//   enc_sts         in   encoder busy / not ready
//   enc_D_TX   [7:0] out byte to encoder
//   enc_D_TX_ready  out  byte-valid strobe to encoder
//   enc_pckt_num [5:0] out packet number, held for the whole packet
//   wdog_err        out  one-cycle pulse on watchdog timeout
module crc_tx_arbiter #(
  parameter int PKT_LEN     = 32,
  parameter int STARVE_MAX  = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic       clk_40mhz,
  input  logic       reset,
  input  logic       req0_avail,
  input  logic [7:0] req0_byte,
  output logic       req0_pop,
  input  logic       req1_avail,
  input  logic [7:0] req1_byte,
  output logic       req1_pop,
  output logic [1:0] grant,
  input  logic       enc_sts,
  output logic [7:0] enc_D_TX,
  output logic       enc_D_TX_ready,
  output logic [5:0] enc_pckt_num,
  output logic       wdog_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_STREAM,
    S_GUARD,
    S_WAIT_DONE
  } state_t;

  localparam logic [7:0] LAST_BYTE  = 8'(PKT_LEN - 1);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [7:0] byte_cnt;
  logic [7:0] starve_cnt;
  logic [5:0] seq;
  logic       guard_cnt;
  logic       arb_voice, arb_data;
  logic       pkt_done;

`ifdef CRC_ARB_WDOG_EN
  localparam logic [12:0] WD_LAST = 13'(WDOG_CYCLES - 1);
  logic [12:0] wd_cnt;
  logic        wd_fire;
  logic        wdog_q;
`endif

  // Next-state and combinational outputs
  always_comb begin
    state_nxt = state;
    req0_pop  = 1'b0;
    req1_pop  = 1'b0;
    arb_voice = 1'b0;
    arb_data  = 1'b0;
    pkt_done  = 1'b0;
`ifdef CRC_ARB_WDOG_EN
    wd_fire   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if ((req0_avail || req1_avail) && !enc_sts) state_nxt = S_ARB;
      end
      S_ARB: begin
        // Voice wins unless data has waited through STARVE_MAX voice grants.
        if (req0_avail && !(req1_avail && starve_cnt == STARVE_LIM)) arb_voice = 1'b1;
        else if (req1_avail) arb_data = 1'b1;
        // Both sources may have withdrawn since IDLE; then nothing is granted.
        state_nxt = (arb_voice || arb_data) ? S_STREAM : S_IDLE;
      end
      S_STREAM: begin
        req0_pop = grant[0];
        req1_pop = grant[1];
        if (byte_cnt == LAST_BYTE) state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (guard_cnt) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!enc_sts) begin
          pkt_done  = 1'b1;
          state_nxt = S_IDLE;
        end
`ifdef CRC_ARB_WDOG_EN
        else if (wd_cnt == WD_LAST) begin
          pkt_done  = 1'b1;
          wd_fire   = 1'b1;
          state_nxt = S_IDLE;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, grant, counters and the registered encoder byte stage
  always_ff @(posedge clk_40mhz or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      grant          <= 2'b00;
      seq            <= '0;
      starve_cnt     <= '0;
      byte_cnt       <= '0;
      guard_cnt      <= 1'b0;
      enc_D_TX       <= '0;
      enc_D_TX_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arb_voice) begin
        grant      <= 2'b01;
        starve_cnt <= req1_avail ? starve_cnt + 8'd1 : 8'd0;
      end
      if (arb_data) begin
        grant      <= 2'b10;
        starve_cnt <= 8'd0;
      end
      if (state == S_ARB) byte_cnt <= 8'd0;
      else if (state == S_STREAM) byte_cnt <= byte_cnt + 8'd1;
      guard_cnt      <= (state == S_GUARD) ? ~guard_cnt : 1'b0;
      enc_D_TX_ready <= (state == S_STREAM);
      if (state == S_STREAM) enc_D_TX <= grant[0] ? req0_byte : req1_byte;
      if (pkt_done) begin
        grant <= 2'b00;
        seq   <= seq + 6'd1;
      end
    end
  end

  assign enc_pckt_num = (state == S_IDLE) ? 6'd0 : seq;

`ifdef CRC_ARB_WDOG_EN
  // Watchdog: counts from GUARD entry through WAIT_DONE
  always_ff @(posedge clk_40mhz or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      wdog_q <= 1'b0;
    end else begin
      wdog_q <= wd_fire;
      if (state == S_STREAM) wd_cnt <= '0;
      else if (state == S_GUARD || state == S_WAIT_DONE) wd_cnt <= wd_cnt + 13'd1;
    end
  end

  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule
